div_ctrl: RTL and testbench



---
 rtl/div_pkg.sv | 33 +++
 rtl/div_step.sv | 24 ++
 rtl/div_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_div_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the DIV/DIVU sequencer.
package div_pkg;

    localparam int XLEN                 = 32;
    localparam int ALIGN_MAX_CYCLES_DEF = 18;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ALIGN  = 3'd2,
        DIVIDE = 3'd3,
        FIXUP  = 3'd4,
        DONE   = 3'd5
    } div_state_t;

    // Two's-complement negation.
    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] value);
        return (~value) + 32'd1;
    endfunction

    // Magnitude of an operand; unsigned operands pass through unchanged.
    function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] value,
                                              input logic            is_signed);
        logic [XLEN-1:0] res;
        if (is_signed && value[XLEN-1]) begin
            res = neg32(value);
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration (purely combinational).
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] r,
    input  logic [XLEN-1:0] d,
    input  logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r_next,
    output logic [XLEN-1:0] q_next,
    output logic            ge
);

    // Subtract when the partial remainder covers the divisor, shift the quotient bit in.
    always_comb begin
        ge     = (r >= d);
        q_next = {q[XLEN-2:0], ge};
        if (ge) begin
            r_next = r - d;
        end else begin
            r_next = r;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer driving an external divisor-alignment unit.
// Optional build macro DIV_CYCLE_STATS_EN adds output last_cycles (cycles
// from accepted start to done, inclusive).
module div_ctrl
    import div_pkg::*;
#(
    parameter int ALIGN_MAX_CYCLES = ALIGN_MAX_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero,
    output logic            align_err,
    output logic            al_rst,
    output logic [XLEN-1:0] al_a,
    output logic [XLEN-1:0] al_b,
    input  logic [XLEN-1:0] al_shiftb,
    input  logic            al_done
`ifdef DIV_CYCLE_STATS_EN
    ,
    output logic [7:0]      last_cycles
`endif
);

    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_MAX_CYCLES - 1);
    localparam logic [7:0] STEP_LAST  = 8'd31;

    div_state_t      state_r;
    div_state_t      state_next_s;

    logic [XLEN-1:0] abs_a_s;
    logic [XLEN-1:0] abs_b_s;
    logic [XLEN-1:0] q_r;
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] d_r;
    logic [XLEN-1:0] abs_b_r;
    logic            sign_a_r;
    logic            sign_b_r;
    logic            dz_r;
    logic            ae_r;
    logic [7:0]      cnt_r;

    logic [XLEN-1:0] r_next_s;
    logic [XLEN-1:0] q_next_s;
    logic            ge_s;
    logic [XLEN-1:0] q_fix_s;
    logic [XLEN-1:0] r_fix_s;
    logic            align_last_s;
    logic            divide_last_s;
    logic            bad_align_s;
    logic            trivial_s;

    logic            busy_s;
    logic            done_s;
    logic            al_rst_s;

    assign abs_a_s       = abs32(dividend, is_signed);
    assign abs_b_s       = abs32(divisor, is_signed);
    assign trivial_s     = (divisor == 32'd0) || (abs_b_s > abs_a_s);
    assign align_last_s  = (cnt_r == ALIGN_LAST);
    // Aligned divisor shifted back to |divisor| ends the loop; the step
    // bound keeps a misbehaving aligner from looping forever.
    assign divide_last_s = (d_r == abs_b_r) || (cnt_r == STEP_LAST);
    // A correctly aligned divisor never exceeds |dividend|, so the first
    // step must subtract; if not, the aligner result is unusable.
    assign bad_align_s   = (cnt_r == 8'd0) && !ge_s;

    div_step u_step (
        .r      (r_r),
        .d      (d_r),
        .q      (q_r),
        .r_next (r_next_s),
        .q_next (q_next_s),
        .ge     (ge_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && trivial_s) begin
                    state_next_s = FIXUP;
                end else if (start) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                state_next_s = ALIGN;
            end
            ALIGN: begin
                if (al_done) begin
                    state_next_s = DIVIDE;
                end else if (align_last_s) begin
                    state_next_s = FIXUP;
                end else begin
                    state_next_s = ALIGN;
                end
            end
            DIVIDE: begin
                if (bad_align_s || divide_last_s) begin
                    state_next_s = FIXUP;
                end else begin
                    state_next_s = DIVIDE;
                end
            end
            FIXUP: begin
                state_next_s = DONE;
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Handshake outputs for the upcoming state (registered below).
    always_comb begin
        busy_s   = 1'b0;
        done_s   = 1'b0;
        al_rst_s = 1'b1;
        case (state_next_s)
            LOAD, FIXUP: begin
                busy_s = 1'b1;
            end
            ALIGN: begin
                busy_s   = 1'b1;
                al_rst_s = 1'b0;
            end
            DIVIDE: begin
                busy_s = 1'b1;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s   = 1'b0;
                done_s   = 1'b0;
                al_rst_s = 1'b1;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            al_rst <= 1'b1;
        end else begin
            busy   <= busy_s;
            done   <= done_s;
            al_rst <= al_rst_s;
        end
    end

    // Sign fix-up of the magnitude result; error paths pass through untouched.
    always_comb begin
        q_fix_s = q_r;
        r_fix_s = r_r;
        if (dz_r || ae_r) begin
            q_fix_s = q_r;
            r_fix_s = r_r;
        end else begin
            if (sign_a_r ^ sign_b_r) begin
                q_fix_s = neg32(q_r);
            end else begin
                q_fix_s = q_r;
            end
            if (sign_a_r) begin
                r_fix_s = neg32(r_r);
            end else begin
                r_fix_s = r_r;
            end
        end
    end

    // Operand capture, alignment wait, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r         <= 32'd0;
            r_r         <= 32'd0;
            d_r         <= 32'd0;
            abs_b_r     <= 32'd0;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            dz_r        <= 1'b0;
            ae_r        <= 1'b0;
            cnt_r       <= 8'd0;
            al_a        <= 32'd0;
            al_b        <= 32'd0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sign_a_r    <= is_signed & dividend[XLEN-1];
                        sign_b_r    <= is_signed & divisor[XLEN-1];
                        al_a        <= abs_a_s;
                        al_b        <= abs_b_s;
                        abs_b_r     <= abs_b_s;
                        ae_r        <= 1'b0;
                        cnt_r       <= 8'd0;
                        div_by_zero <= 1'b0;
                        align_err   <= 1'b0;
                        if (divisor == 32'd0) begin
                            dz_r <= 1'b1;
                            q_r  <= 32'hFFFF_FFFF;
                            r_r  <= dividend;
                        end else begin
                            dz_r <= 1'b0;
                            q_r  <= 32'd0;
                            r_r  <= abs_a_s;
                        end
                    end
                end
                LOAD: begin
                    cnt_r <= 8'd0;
                end
                ALIGN: begin
                    if (al_done) begin
                        d_r   <= al_shiftb;
                        r_r   <= al_a;
                        q_r   <= 32'd0;
                        cnt_r <= 8'd0;
                    end else if (align_last_s) begin
                        ae_r <= 1'b1;
                        q_r  <= 32'd0;
                        r_r  <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                DIVIDE: begin
                    if (bad_align_s) begin
                        ae_r <= 1'b1;
                        q_r  <= 32'd0;
                        r_r  <= 32'd0;
                    end else begin
                        r_r   <= r_next_s;
                        q_r   <= q_next_s;
                        d_r   <= d_r >> 1;
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                FIXUP: begin
                    quotient    <= q_fix_s;
                    remainder   <= r_fix_s;
                    div_by_zero <= dz_r;
                    align_err   <= ae_r;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

`ifdef DIV_CYCLE_STATS_EN
    logic [7:0] cyc_r;

    // Cycle accounting: the start cycle is cycle 1, captured as of the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r       <= 8'd0;
            last_cycles <= 8'd0;
        end else begin
            if (state_r == IDLE && start) begin
                cyc_r <= 8'd2;
            end else if (busy) begin
                cyc_r <= cyc_r + 8'd1;
            end else begin
                cyc_r <= cyc_r;
            end
            if (state_r == FIXUP) begin
                last_cycles <= cyc_r + 8'd1;
            end else begin
                last_cycles <= last_cycles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural alignment-unit model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        align_err;
    logic        al_rst;
    logic [31:0] al_a;
    logic [31:0] al_b;
    logic [31:0] al_shiftb;
    logic        al_done;
`ifdef DIV_CYCLE_STATS_EN
    logic [7:0]  last_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int al_lat = 2;     // cycles of al_rst low before al_done; 0 = never
    int al_cnt = 0;

    div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .align_err  (align_err),
        .al_rst     (al_rst),
        .al_a       (al_a),
        .al_b       (al_b),
        .al_shiftb  (al_shiftb),
        .al_done    (al_done)
`ifdef DIV_CYCLE_STATS_EN
        ,
        .last_cycles(last_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Largest b<<k that neither overflows nor exceeds a.
    function automatic logic [31:0] align_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = b;
        if (s != 32'd0) begin
            for (int i = 0; i < 32; i++) begin
                if (!s[31] && ((s << 1) <= a)) s = s << 1;
            end
        end
        return s;
    endfunction

    // Alignment unit model: counts cycles with al_rst low.
    always @(posedge clk) begin
        if (al_rst) al_cnt <= 0;
        else        al_cnt <= al_cnt + 1;
    end
    assign al_done   = !al_rst && (al_lat != 0) && (al_cnt >= al_lat - 1);
    assign al_shiftb = align_ref(al_a, al_b);

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat_al;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ae;
        int          lat;
        logic        restart;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ae;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[13];
    vec_t v_after;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   lat;
        bit   seen;
        bit   low_seen;
        int   extra;
        al_lat = v.lat_al;
        @(negedge clk);
        start     = 1'b1;
        is_signed = v.sgn;
        dividend  = v.a;
        divisor   = v.b;
        e.q = v.q; e.r = v.r; e.dz = v.dz; e.ae = v.ae; e.lat = v.lat;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 2;
        seen     = 1'b0;
        low_seen = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        while (!seen && lat < 100) begin
            if (!al_rst) low_seen = 1'b1;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (v.restart && lat == 5) begin
                    start    = 1'b1;
                    dividend = 32'd5;
                    divisor  = 32'd0;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
            chk("align_err", {31'd0, align_err}, {31'd0, e.ae});
            chk("latency", 32'(lat), 32'(e.lat));
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            if (e.lat == 3) chk("al_rst_low_on_trivial", {31'd0, low_seen}, 32'd0);
`ifdef DIV_CYCLE_STATS_EN
            chk("last_cycles", {24'd0, last_cycles}, 32'(e.lat));
`endif
            @(posedge clk); #1;
            chk("done_pulse_width", {31'd0, done}, 32'd0);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
            chk("results_held", quotient, e.q);
            extra = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            chk("extra_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        //          sgn   a             b             al  q             r             dz    ae    lat restart
        vecs[0]  = '{1'b0, 32'd100,      32'd7,        2, 32'd14,       32'd2,        1'b0, 1'b0, 10, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        2, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 10, 1'b0};
        vecs[2]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 2, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 10, 1'b0};
        vecs[3]  = '{1'b0, 32'd5,        32'd0,        2, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 3,  1'b0};
        vecs[4]  = '{1'b0, 32'd3,        32'd10,       2, 32'd0,        32'd3,        1'b0, 1'b0, 3,  1'b0};
        vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 2, 32'h80000000, 32'd0,        1'b0, 1'b0, 38, 1'b1};
        vecs[6]  = '{1'b0, 32'd100,      32'd7,        0, 32'd0,        32'd0,        1'b0, 1'b1, 22, 1'b0};
        vecs[7]  = '{1'b0, 32'd7,        32'd7,        2, 32'd1,        32'd0,        1'b0, 1'b0, 7,  1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 8,  1'b0};
        vecs[9]  = '{1'b1, 32'hFFFFFFFB, 32'd0,        2, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 3,  1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFFD, 32'd10,       2, 32'd0,        32'hFFFFFFFD, 1'b0, 1'b0, 3,  1'b0};
        vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'd1,        1, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 37, 1'b0};
        vecs[12] = '{1'b0, 32'd100,      32'd7,       18, 32'd14,       32'd2,        1'b0, 1'b0, 26, 1'b0};
        v_after  = '{1'b0, 32'd9,        32'd3,        2, 32'd3,        32'd0,        1'b0, 1'b0, 8,  1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        chk("rst_align_err", {31'd0, align_err}, 32'd0);
        chk("rst_al_rst", {31'd0, al_rst}, 32'd1);
        chk("rst_al_a", al_a, 32'd0);
        chk("rst_al_b", al_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset in the middle of a long DIVIDE phase
        al_lat = 2;
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'hFFFFFFFF;
        divisor   = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_al_rst", {31'd0, al_rst}, 32'd1);
        @(posedge clk); #1;
        chk("midrst_no_done", {31'd0, done}, 32'd0);

        run_vec(v_after);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
